// File: rtl/instr_fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_ctrl_pkg
// Shared types for the instruction fetch controller:
//   WORD_W         - width of instruction words and word-index addresses
//   fetch_state_e  - controller states IDLE / RUN / HALT
//   fetch_entry_t  - one fetch-buffer entry {pc, instr}
// ---------------------------------------------------------------------------
package instr_fetch_ctrl_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_ctrl_if
// Bundles the instruction-memory bus and the decode-side output stream.
//   imem_addr   word index presented to the combinational instruction memory
//   imem_instr  instruction word returned for imem_addr in the same cycle
//   out_valid   head of the fetch buffer holds a valid instruction
//   out_instr   head instruction word (0 when out_valid=0)
//   out_pc      word index of out_instr (0 when out_valid=0)
//   out_ready   decode accepts the head this cycle
// Modports: master = fetch controller, slave = memory/decode environment.
// ---------------------------------------------------------------------------
interface instr_fetch_ctrl_if;
    import instr_fetch_ctrl_pkg::*;

    logic [WORD_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_instr;
    logic              out_valid;
    logic [WORD_W-1:0] out_instr;
    logic [WORD_W-1:0] out_pc;
    logic              out_ready;

    modport master (
        output imem_addr,
        input  imem_instr,
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready
    );

endinterface

// File: rtl/instr_fetch_ctrl_fetch_fifo2.sv
// ---------------------------------------------------------------------------
// fetch_fifo2
// Two-entry FIFO of fetch entries with synchronous flush.
//   clk, rst_n  clock, asynchronous active-low reset
//   i_flush     drop all entries (overrides push and pop)
//   i_push      write i_entry; accepted when not full or popping this cycle
//   i_pop       remove the head; ignored when empty
//   i_entry     entry to write
//   o_head      oldest entry (only meaningful when o_count != 0)
//   o_count     number of stored entries, 0..2
// ---------------------------------------------------------------------------
module fetch_fifo2
    import instr_fetch_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic         i_pop,
    input  fetch_entry_t i_entry,
    output fetch_entry_t o_head,
    output logic [1:0]   o_count
);

    fetch_entry_t r_mem [2];
    logic         r_rdPtr;
    logic [1:0]   r_count;

    logic w_doPop;
    logic w_doPush;
    logic w_wrPtr;

    // Qualify the requests against occupancy. The write slot is rdPtr when
    // the FIFO is empty or full (full+pop reuses the slot being freed) and
    // the other slot when exactly one entry is held.
    always_comb begin
        w_doPop  = i_pop && (r_count != 2'd0);
        w_doPush = i_push && ((r_count != 2'd2) || w_doPop);
        w_wrPtr  = r_rdPtr ^ r_count[0];
    end

    // Storage, read pointer and occupancy. Flush simply empties the FIFO;
    // stale data left in the slots is never shown because count is zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rdPtr  <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_rdPtr <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_doPush) begin
                r_mem[w_wrPtr] <= i_entry;
            end
            if (w_doPop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rdPtr];
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// instr_fetch_ctrl
// Instruction fetch controller: walks a word-index pc through a
// combinational instruction memory, buffers up to two fetched
// {pc, instr} entries for decode, and redirects on resolved branches.
//
// Parameters
//   MEM_DEPTH  instruction memory depth in words (bounds check limit)
//   RESET_PC   word index fetched first after start
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   i_start      level; leaves IDLE and begins fetching
//   i_br_taken   redirect request
//   i_br_target  absolute word index of the redirect target
//   o_fault      fetch address out of range (bounds check builds only)
//   bus          instr_fetch_ctrl_if.master: imem bus + output stream
//
// Build option: define FETCH_BOUNDS_CHECK_EN to stop fetching at
// pc >= MEM_DEPTH, raise o_fault and park in HALT until a redirect to an
// in-range target. Without it o_fault is 0 and every pc is fetched.
// ---------------------------------------------------------------------------
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter int unsigned       MEM_DEPTH = 100,
    parameter logic [WORD_W-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_br_taken,
    input  logic [WORD_W-1:0]    i_br_target,
    output logic                 o_fault,
    instr_fetch_ctrl_if.master   bus
);

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    fetch_state_e      r_state;
    fetch_state_e      w_nextState;
    logic [WORD_W-1:0] r_pc;

    logic         w_pcOutOfRange;
    logic         w_targetInRange;
    logic         w_flush;
    logic         w_pushReq;
    logic         w_pushOk;
    logic         w_pop;
    logic         w_outValid;
    logic [1:0]   w_count;
    fetch_entry_t w_entry;
    fetch_entry_t w_head;

    // Range checks only bite when the bounds option is built in.
    assign w_pcOutOfRange  = BOUNDS_EN && (r_pc >= WORD_W'(MEM_DEPTH));
    assign w_targetInRange = !BOUNDS_EN || (i_br_target < WORD_W'(MEM_DEPTH));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. A redirect in RUN beats the bounds fault, so a
    // branch issued while pc is out of range keeps the controller running.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (i_start) w_nextState = RUN;
            RUN:  if (!i_br_taken && w_pcOutOfRange) w_nextState = HALT;
            HALT: if (i_br_taken && w_targetInRange) w_nextState = RUN;
            default: w_nextState = IDLE;
        endcase
    end

    // Output/control decode. Branches flush the buffer in RUN and HALT;
    // only RUN with an in-range pc requests new fetches. HALT is only ever
    // entered through the bounds fault, so it doubles as the fault flag.
    always_comb begin
        w_flush   = 1'b0;
        w_pushReq = 1'b0;
        case (r_state)
            RUN: begin
                if (i_br_taken) begin
                    w_flush = 1'b1;
                end else if (!w_pcOutOfRange) begin
                    w_pushReq = 1'b1;
                end
            end
            HALT: begin
                w_flush = i_br_taken;
            end
            default: begin
                w_flush   = 1'b0;
                w_pushReq = 1'b0;
            end
        endcase
        o_fault = BOUNDS_EN && (r_state == HALT);
    end

    // A push only lands when the FIFO has room, counting the slot freed by
    // a same-cycle pop; pc must advance on exactly those cycles.
    assign w_outValid = (w_count != 2'd0);
    assign w_pop      = w_outValid && bus.out_ready;
    assign w_pushOk   = w_pushReq && ((w_count != 2'd2) || w_pop);
    assign w_entry    = {r_pc, bus.imem_instr};

    // Program counter: redirect first, then sequential advance on push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (w_flush) begin
            r_pc <= i_br_target;
        end else if (w_pushOk) begin
            r_pc <= r_pc + WORD_W'(1);
        end
    end

    fetch_fifo2 u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_flush),
        .i_push  (w_pushOk),
        .i_pop   (w_pop),
        .i_entry (w_entry),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign bus.imem_addr = r_pc;
    assign bus.out_valid = w_outValid;
    assign bus.out_instr = w_outValid ? w_head.instr : '0;
    assign bus.out_pc    = w_outValid ? w_head.pc    : '0;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_ctrl
// Directed bench for instr_fetch_ctrl. A queue-based reference model tracks
// the fetch buffer and pc; a compare process checks every output on each
// falling edge, and the stimulus adds literal expectations at key cycles.
// Works with or without FETCH_BOUNDS_CHECK_EN defined.
// ---------------------------------------------------------------------------
module tb_instr_fetch_ctrl;

    localparam int unsigned MEM_DEPTH = 100;
    localparam logic [31:0] RESET_PC  = 32'd0;

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic        brTaken  = 1'b0;
    logic [31:0] brTarget = 32'd0;
    logic        ready    = 1'b0;
    logic        fault;

    int checks   = 0;
    int failures = 0;

    ent_t        mQ[$];
    logic [31:0] mPc     = RESET_PC;
    bit          mActive = 1'b0;
    bit          mHalted = 1'b0;

    instr_fetch_ctrl_if bus();

    instr_fetch_ctrl #(
        .MEM_DEPTH (MEM_DEPTH),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (start),
        .i_br_taken  (brTaken),
        .i_br_target (brTarget),
        .o_fault     (fault),
        .bus         (bus)
    );

    // Memory contents are a simple tag of the address so instr and pc differ.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign bus.imem_instr = memWord(bus.imem_addr);
    assign bus.out_ready  = ready;

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference behaviour for one clock edge (or an asynchronous reset).
    task automatic modelStep();
        bit   pop;
        ent_t e;
        if (!rst_n) begin
            mQ.delete();
            mPc     = RESET_PC;
            mActive = 1'b0;
            mHalted = 1'b0;
            return;
        end
        pop = (mQ.size() > 0) && ready;
        if (!mActive) begin
            if (start) mActive = 1'b1;
        end else if (brTaken) begin
            mQ.delete();
            if (mHalted && (!BOUNDS || brTarget < MEM_DEPTH)) mHalted = 1'b0;
            mPc = brTarget;
        end else begin
            if (pop) void'(mQ.pop_front());
            if (!mHalted) begin
                if (BOUNDS && mPc >= MEM_DEPTH) begin
                    mHalted = 1'b1;
                end else if (mQ.size() < 2) begin
                    e.pc    = mPc;
                    e.instr = memWord(mPc);
                    mQ.push_back(e);
                    mPc = mPc + 32'd1;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            modelStep();
        end
    end

    // Every falling edge: all observable outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("m_out_valid", {31'd0, bus.out_valid}, {31'd0, mQ.size() > 0});
            checkOutput("m_out_pc", bus.out_pc, (mQ.size() > 0) ? mQ[0].pc : 32'd0);
            checkOutput("m_out_instr", bus.out_instr, (mQ.size() > 0) ? mQ[0].instr : 32'd0);
            checkOutput("m_imem_addr", bus.imem_addr, mPc);
            checkOutput("m_fault", {31'd0, fault}, {31'd0, mHalted});
        end
    end

    task automatic applyStimulus(input logic s, input logic r, input logic b,
                                 input logic [31:0] t);
        start    = s;
        ready    = r;
        brTaken  = b;
        brTarget = t;
    endtask

    // Assert reset at the current time, check the reset values, release at
    // the next falling edge (caller continues from that edge).
    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, ready, 1'b0, 32'd0);
        #1;
        checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("rst_out_pc", bus.out_pc, 32'd0);
        checkOutput("rst_out_instr", bus.out_instr, 32'd0);
        checkOutput("rst_fault", {31'd0, fault}, 32'd0);
        checkOutput("rst_imem_addr", bus.imem_addr, RESET_PC);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        $display("[TB] start");

        // Reset, then a branch while idle must be ignored.
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b1, 32'd50);
        @(negedge clk);
        checkOutput("idle_br_imem", bus.imem_addr, 32'd0);
        checkOutput("idle_br_valid", {31'd0, bus.out_valid}, 32'd0);

        // Streaming: out_pc 0,1,2,... from cycle 2 after start.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        @(negedge clk);
        checkOutput("s_c1_valid", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        checkOutput("s_c2_pc", bus.out_pc, 32'd0);
        checkOutput("s_c2_instr", bus.out_instr, 32'hC0DE_0000);
        start = 1'b0;
        @(negedge clk);
        checkOutput("s_c3_pc", bus.out_pc, 32'd1);
        @(negedge clk);
        checkOutput("s_c4_pc", bus.out_pc, 32'd2);
        checkOutput("s_c4_instr", bus.out_instr, 32'hC0DE_0002);
        @(negedge clk);
        checkOutput("s_c5_pc", bus.out_pc, 32'd3);

        // Back-pressure: ready low for 5 cycles after start.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("bp_c3_imem", bus.imem_addr, 32'd2);
        repeat (2) @(negedge clk);
        checkOutput("bp_c5_imem", bus.imem_addr, 32'd2);
        checkOutput("bp_c5_pc", bus.out_pc, 32'd0);
        checkOutput("bp_c5_valid", {31'd0, bus.out_valid}, 32'd1);
        ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_c6_pc", bus.out_pc, 32'd1);
        @(negedge clk);
        checkOutput("bp_c7_pc", bus.out_pc, 32'd2);
        @(negedge clk);
        checkOutput("bp_c8_pc", bus.out_pc, 32'd3);

        // Fill with pcs 10,11 then redirect to 39 with a pop pending.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'd10);
        @(negedge clk);
        checkOutput("br_d1_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("br_d1_imem", bus.imem_addr, 32'd10);
        brTaken = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("br_d3_pc", bus.out_pc, 32'd10);
        checkOutput("br_d3_imem", bus.imem_addr, 32'd12);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'd39);
        @(negedge clk);
        checkOutput("br_d4_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("br_d4_imem", bus.imem_addr, 32'd39);
        brTaken = 1'b0;
        @(negedge clk);
        checkOutput("br_d5_pc", bus.out_pc, 32'd39);
        checkOutput("br_d5_instr", bus.out_instr, 32'hC0DE_0027);
        @(negedge clk);
        checkOutput("br_d6_pc", bus.out_pc, 32'd40);

        // Run off the end of memory at 98,99,100.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'd98);
        @(negedge clk);
        brTaken = 1'b0;
        @(negedge clk);
        checkOutput("bd_e2_pc", bus.out_pc, 32'd98);
        @(negedge clk);
        checkOutput("bd_e3_pc", bus.out_pc, 32'd99);
        checkOutput("bd_e3_imem", bus.imem_addr, 32'd100);
        @(negedge clk);
`ifdef FETCH_BOUNDS_CHECK_EN
        checkOutput("bd_e4_fault", {31'd0, fault}, 32'd1);
        checkOutput("bd_e4_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("bd_e4_imem", bus.imem_addr, 32'd100);
`else
        checkOutput("bd_e4_fault", {31'd0, fault}, 32'd0);
        checkOutput("bd_e4_pc", bus.out_pc, 32'd100);
`endif
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'd0);
        @(negedge clk);
        checkOutput("bd_e6_fault", {31'd0, fault}, 32'd0);
        checkOutput("bd_e6_imem", bus.imem_addr, 32'd0);
        brTaken = 1'b0;
        @(negedge clk);
        checkOutput("bd_e7_pc", bus.out_pc, 32'd0);
        checkOutput("bd_e7_instr", bus.out_instr, 32'hC0DE_0000);

        // Mixed ready pattern with one redirect, checked by the model only.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, (i % 3) != 0, i == 7, 32'd20);
            @(negedge clk);
        end

        // Fill the buffer, then reset mid-cycle.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("ar_full_valid", {31'd0, bus.out_valid}, 32'd1);
        #2;
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        @(negedge clk);
        checkOutput("ar_c1_valid", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        checkOutput("ar_c2_pc", bus.out_pc, RESET_PC);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 Parameters: MEM_DEPTH, default 100, instruction memory depth in words; RESET_PC, default 0, word index fetched first after start.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  level; leaves IDLE and begins fetching.
REQ-005 imem_addr  output  32  word index driven to the combinational instruction memory.
REQ-006 imem_instr  input  32  instruction word returned for imem_addr in the same cycle.
REQ-007 br_taken  input  1  redirect request (branch/jump resolved).
REQ-008 br_target  input  32  absolute word index of the redirect target.
REQ-009 out_valid  output  1  head of fetch buffer holds a valid instruction.
REQ-010 out_instr  output  32  head instruction word.
REQ-011 out_pc  output  32  word index of out_instr.
REQ-012 out_ready  input  1  decode accepts the head; transfer when out_valid and out_ready.
REQ-013 fault  output  1  fetch address out of range (see Configuration).

Function
REQ-014 FSM states IDLE, RUN, HALT; IDLE->RUN when start=1; RUN->HALT on bounds fault; HALT->RUN only on br_taken with in-range br_target; no other transitions.
REQ-015 imem_addr shall equal pc in every state.
REQ-016 2-entry FIFO of {pc, instr}; out_* reflect the oldest entry; out_instr/out_pc are 0 when out_valid=0.
REQ-017 Push in RUN when (count<2 or pop this cycle) and no br_taken and no fault: entry {pc, imem_instr}; pc <= pc+1 (32-bit wrap).
REQ-018 Latency: instruction addressed in cycle N appears on out_* in cycle N+1 at the earliest.
REQ-019 Full buffer without pop: no push, pc holds (stall).
REQ-020 Simultaneous push and pop when full: both occur, count stays 2.
REQ-021 br_taken (any state except IDLE) has priority: both entries flushed, pending pop discarded, pc <= br_target, no push that cycle; first target instruction visible two cycles after the br_taken cycle.
REQ-022 br_taken in IDLE is ignored.
REQ-023 start deasserting in RUN has no effect.

Reset
REQ-024 On rst=0, immediately: state IDLE, pc=RESET_PC, FIFO empty, out_valid=0, out_instr=0, out_pc=0, fault=0.
REQ-025 Reset mid-operation discards all buffered entries; no partial transfer is observable.

Configuration
REQ-026 Macro FETCH_BOUNDS_CHECK_EN: when defined, pc >= MEM_DEPTH in RUN suppresses the push, sets fault=1, enters HALT; fault clears on valid redirect out of HALT or on reset; buffered entries remain drainable in HALT.
REQ-027 Without FETCH_BOUNDS_CHECK_EN: fault tied 0, HALT unreachable, any pc fetched.

Structure
REQ-028 Shared package holds the FSM state enum (IDLE, RUN, HALT), the fetch-entry struct {pc, instr}, and the 32-bit word width constant.
REQ-029 One sub-module, fetch_fifo2 (2-entry FIFO with flush, push, pop, count), instantiated once.

Verification
REQ-030 Reset, start=1, out_ready=1, memory = index value: out_pc 0,1,2,... on consecutive cycles from cycle 2 after start, out_instr = out_pc.
REQ-031 out_ready=0 for 5 cycles after start: out_valid=1, count reaches 2, pc held at RESET_PC+2, out_pc stays 0; release -> 0,1,2,3 with no gap or duplicate.
REQ-032 br_taken with br_target=39 while buffer holds pcs 10,11: entries flushed, next valid out_pc=39, pcs 10/11 never transferred after flush.
REQ-033 FETCH_BOUNDS_CHECK_EN, MEM_DEPTH=100, start at RESET_PC=98: out_pc 98,99 delivered, fault=1, HALT, no pc 100; br_taken target 0 -> fault=0, out_pc 0 follows.
REQ-034 rst=0 asserted mid-run with buffer full: out_valid drops asynchronously to 0; after release and start, first out_pc = RESET_PC.
